// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and a word-wide,
// byte-enabled data memory (slave).
interface load_store_unit_if #(
  parameter int Width = 32
);
  logic             mem_req;
  logic             mem_we;
  logic [Width-3:0] mem_addr;
  logic [3:0]       mem_be;
  logic [Width-1:0] mem_wdata;
  logic             mem_gnt;
  logic             mem_rvalid;
  logic [Width-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns core load/store requests into req/gnt/rvalid beats
// on a word-wide byte-enabled memory, splitting word-crossing accesses into
// two beats and merging/extending load data.
//
// Optional build macro MISALIGN_TRAP_EN: when defined, any access that is
// not naturally aligned is rejected with err instead of being split.
//
// state | meaning
// IDLE  | waiting for MemRead/MemWrite
// REQ0  | first beat requested, waiting for mem_gnt (or rejected request)
// WAIT0 | first read beat granted, waiting for mem_rvalid
// REQ1  | second beat of a split access requested, waiting for mem_gnt
// WAIT1 | second read beat granted, waiting for mem_rvalid
// DONE  | one-cycle completion, done/err/R_Data valid
module load_store_unit #(
  parameter int Width         = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      MemRead,
  input  logic                      MemWrite,
  input  logic [2:0]                Mode,
  input  logic [Width-1:0]          Address,
  input  logic [Width-1:0]          W_Data,
  output logic [Width-1:0]          R_Data,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  load_store_unit_if.master         mem
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Per-beat timeout counter counts down from TimeoutCycles-1 to zero.
  localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  state_t           state;
  logic [CntW-1:0]  cnt;
  logic             timeout_hit;

  logic             is_wr_q;
  logic             reject_q;
  logic             split_q;
  logic [2:0]       mode_q;
  logic [1:0]       off_q;
  logic [Width-3:0] addr1_q;
  logic [3:0]       be1_q;
  logic [Width-1:0] wdata1_q;
  logic [Width-1:0] rdata0_q;

  logic             req_q;
  logic             we_q;
  logic [Width-3:0] addr_q;
  logic [3:0]       be_q;
  logic [Width-1:0] wdata_q;

  logic [1:0]         off_d;
  logic [3:0]         mask_d;
  logic [7:0]         be_wide_d;
  logic [2*Width-1:0] wd_wide_d;
  logic               illegal_d;
  logic               reject_d;
  logic               split_d;

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

  assign timeout_hit = (TimeoutCycles != 0) && (cnt == '0);

  // Shift a 64-bit {high word, low word} pair down to the access offset and
  // sign/zero-extend the selected bytes.
  function automatic logic [Width-1:0] extend_load(
    input logic [2*Width-1:0] pair,
    input logic [1:0]         off,
    input logic [2:0]         mode
  );
    logic [Width-1:0] sh;
    logic [Width-1:0] res;
    sh = Width'(pair >> {off, 3'b000});
    case (mode)
      3'b000:  res = {{(Width-8){sh[7]}}, sh[7:0]};
      3'b001:  res = {{(Width-16){sh[15]}}, sh[15:0]};
      3'b011:  res = {{(Width-8){1'b0}}, sh[7:0]};
      3'b100:  res = {{(Width-16){1'b0}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  // Decode the incoming request: size mask, lane-shifted enables/data for
  // both potential beats, and whether the request must be rejected.
  always_comb begin
    off_d = Address[1:0];
    case (Mode)
      3'b000, 3'b011, 3'b101: mask_d = 4'b0001;
      3'b001, 3'b100, 3'b110: mask_d = 4'b0011;
      default:                mask_d = 4'b1111;
    endcase
    be_wide_d = {4'b0000, mask_d} << off_d;
    wd_wide_d = {{Width{1'b0}}, W_Data} << {off_d, 3'b000};
    split_d   = |be_wide_d[7:4];
    illegal_d = MemWrite ? (Mode <= 3'd4) : (Mode >= 3'd5);
`ifdef MISALIGN_TRAP_EN
    reject_d  = illegal_d
              | ((mask_d == 4'b0011) && off_d[0])
              | ((mask_d == 4'b1111) && (off_d != 2'b00));
`else
    reject_d  = illegal_d;
`endif
  end

  // Main controller: sequences beats and registers every output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      is_wr_q  <= 1'b0;
      reject_q <= 1'b0;
      split_q  <= 1'b0;
      mode_q   <= '0;
      off_q    <= '0;
      addr1_q  <= '0;
      be1_q    <= '0;
      wdata1_q <= '0;
      rdata0_q <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      R_Data   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          err <= 1'b0;
          if (MemRead || MemWrite) begin
            busy     <= 1'b1;
            is_wr_q  <= MemWrite;
            reject_q <= reject_d;
            split_q  <= split_d;
            mode_q   <= Mode;
            off_q    <= off_d;
            addr1_q  <= Address[Width-1:2] + 1'b1;
            be1_q    <= be_wide_d[7:4];
            wdata1_q <= wd_wide_d[2*Width-1:Width];
            req_q    <= !reject_d;
            we_q     <= MemWrite;
            addr_q   <= Address[Width-1:2];
            be_q     <= be_wide_d[3:0];
            wdata_q  <= wd_wide_d[Width-1:0];
            cnt      <= CntLoad;
            state    <= REQ0;
          end
        end
        REQ0: begin
          if (reject_q) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (mem.mem_gnt) begin
            if (is_wr_q && split_q) begin
              addr_q  <= addr1_q;
              be_q    <= be1_q;
              wdata_q <= wdata1_q;
              cnt     <= CntLoad;
              state   <= REQ1;
            end else if (is_wr_q) begin
              req_q <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              req_q <= 1'b0;
              state <= WAIT0;
            end
          end else if (timeout_hit) begin
            req_q <= 1'b0;
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT0: begin
          if (mem.mem_rvalid) begin
            rdata0_q <= mem.mem_rdata;
            if (split_q) begin
              req_q   <= 1'b1;
              addr_q  <= addr1_q;
              be_q    <= be1_q;
              wdata_q <= wdata1_q;
              cnt     <= CntLoad;
              state   <= REQ1;
            end else begin
              R_Data <= extend_load({{Width{1'b0}}, mem.mem_rdata}, off_q, mode_q);
              done   <= 1'b1;
              state  <= DONE;
            end
          end else if (timeout_hit) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        REQ1: begin
          if (mem.mem_gnt) begin
            req_q <= 1'b0;
            if (is_wr_q) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= WAIT1;
            end
          end else if (timeout_hit) begin
            req_q <= 1'b0;
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT1: begin
          if (mem.mem_rvalid) begin
            R_Data <= extend_load({mem.mem_rdata, rdata0_q}, off_q, mode_q);
            done   <= 1'b1;
            state  <= DONE;
          end else if (timeout_hit) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          req_q <= 1'b0;
          busy  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a zero-wait byte-enabled memory
// model that logs every granted beat.
module tb_load_store_unit;

`ifdef MISALIGN_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Mode;
  logic [31:0] Address;
  logic [31:0] W_Data;
  logic [31:0] R_Data;
  logic        busy;
  logic        done;
  logic        err;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Mode     (Mode),
    .Address  (Address),
    .W_Data   (W_Data),
    .R_Data   (R_Data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] w0;
    logic [31:0] w1;
    int          beats;
    logic [29:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [29:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    int          lat;
    logic        e;
    logic [31:0] rdata;
    logic        mis;
    logic [31:0] mem_after;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  int cur_tag = 0;
  logic [31:0] exp_r = 32'h0;
  int last_req_hi = 0;

  logic [31:0] mem_words [64];
  logic        gnt_en = 1'b1;
  logic        rd_pending = 1'b0;
  logic [5:0]  rd_idx = '0;
  int          nbeats = 0;
  logic [29:0] log_addr [4];
  logic [3:0]  log_be [4];
  logic [31:0] log_wd [4];
  logic        log_we [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL t%0d %s: got %h expected %h", cur_tag, name, act, expv);
    end
  endtask

  // Memory model: decides gnt/rvalid on the falling edge from the stable
  // registered request, logs beats and applies byte-enabled writes.
  always @(negedge clk) begin
    if (rd_pending) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mem_words[rd_idx];
      rd_pending     = 1'b0;
    end else begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'h0;
    end
    if (bus.mem_req === 1'b1 && gnt_en) begin
      bus.mem_gnt = 1'b1;
      if (nbeats < 4) begin
        log_addr[nbeats] = bus.mem_addr;
        log_be[nbeats]   = bus.mem_be;
        log_wd[nbeats]   = bus.mem_wdata;
        log_we[nbeats]   = bus.mem_we;
      end
      nbeats++;
      if (bus.mem_we) begin
        for (int l = 0; l < 4; l++)
          if (bus.mem_be[l]) mem_words[bus.mem_addr[5:0]][8*l +: 8] = bus.mem_wdata[8*l +: 8];
      end else begin
        rd_pending = 1'b1;
        rd_idx     = bus.mem_addr[5:0];
      end
    end else begin
      bus.mem_gnt = 1'b0;
    end
  end

  task automatic run_vec(input vec_t v);
    int cyc;
    int req_hi;
    bit seen;
    logic [5:0] idx0;
    logic [5:0] idx1;
    idx0 = v.addr[7:2];
    idx1 = idx0 + 6'd1;
    mem_words[idx0] = v.w0;
    mem_words[idx1] = v.w1;
    nbeats = 0;
    @(negedge clk);
    MemRead  = v.rd;
    MemWrite = v.wr;
    Mode     = v.mode;
    Address  = v.addr;
    W_Data   = v.wdata;
    @(posedge clk);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    chk("busy_start", busy, 1);
    cyc = 1;
    req_hi = 0;
    seen = 0;
    while (cyc <= 400) begin
      if (bus.mem_req === 1'b1) req_hi++;
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    last_req_hi = req_hi;
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL t%0d done_wait: no done after %0d cycles, required at +%0d", cur_tag, cyc, v.lat);
    end else begin
      if (!v.wr && !v.e) exp_r = v.rdata;
      chk("latency", cyc, v.lat);
      chk("err", err, v.e);
      chk("r_data", R_Data, exp_r);
      chk("req_at_done", bus.mem_req, 0);
      chk("beats", nbeats, v.beats);
      if (v.beats > 0 && nbeats > 0) begin
        chk("addr0", 32'(log_addr[0]), 32'(v.a0));
        chk("be0", 32'(log_be[0]), 32'(v.be0));
        chk("wdata0", log_wd[0], v.wd0);
        chk("we0", 32'(log_we[0]), 32'(v.wr));
      end
      if (v.beats > 1 && nbeats > 1) begin
        chk("addr1", 32'(log_addr[1]), 32'(v.a1));
        chk("be1", 32'(log_be[1]), 32'(v.be1));
        chk("wdata1", log_wd[1], v.wd1);
        chk("we1", 32'(log_we[1]), 32'(v.wr));
      end
      if (v.wr && v.beats > 0) chk("mem_word", mem_words[idx0], v.mem_after);
    end
    @(posedge clk);
    #1;
    chk("busy_idle", busy, 0);
  endtask

  vec_t vecs [16];
  vec_t hv;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 64; k++) mem_words[k] = 32'h0;
    reset = 1'b1;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    Mode = 3'b000;
    Address = 32'h0;
    W_Data = 32'h0;

    //          rd wr mode    addr          wdata         w0            w1            bt a0          be0    wd0           a1      be1    wd1           lat e  rdata         mis mem_after
    vecs[0]  = '{0, 1, 3'b111, 32'h10,       32'hDEADBEEF, 32'h0,        32'h0,        1, 30'h4,       4'hF,  32'hDEADBEEF, 30'h0,  4'h0,  32'h0,        2, 0, 32'h0,        0, 32'hDEADBEEF};
    vecs[1]  = '{0, 1, 3'b101, 32'h13,       32'h000000A5, 32'hDEADBEEF, 32'h0,        1, 30'h4,       4'h8,  32'hA5000000, 30'h0,  4'h0,  32'h0,        2, 0, 32'h0,        0, 32'hA5ADBEEF};
    vecs[2]  = '{1, 0, 3'b000, 32'h2,        32'h0,        32'h00F00000, 32'h0,        1, 30'h0,       4'h4,  32'h0,        30'h0,  4'h0,  32'h0,        3, 0, 32'hFFFFFFF0, 0, 32'h0};
    vecs[3]  = '{1, 0, 3'b011, 32'h2,        32'h0,        32'h00F00000, 32'h0,        1, 30'h0,       4'h4,  32'h0,        30'h0,  4'h0,  32'h0,        3, 0, 32'h000000F0, 0, 32'h0};
    vecs[4]  = '{1, 0, 3'b001, 32'h7,        32'h0,        32'hAB000000, 32'h000000CD, 2, 30'h1,       4'h8,  32'h0,        30'h2,  4'h1,  32'h0,        5, 0, 32'hFFFFCDAB, 1, 32'h0};
    vecs[5]  = '{0, 1, 3'b111, 32'hE,        32'h11223344, 32'h0,        32'h0,        2, 30'h3,       4'hC,  32'h33440000, 30'h4,  4'h3,  32'h00001122, 3, 0, 32'h0,        1, 32'h33440000};
    vecs[6]  = '{1, 0, 3'b100, 32'h6,        32'h0,        32'h87654321, 32'h0,        1, 30'h1,       4'hC,  32'h0,        30'h0,  4'h0,  32'h0,        3, 0, 32'h00008765, 0, 32'h0};
    vecs[7]  = '{1, 0, 3'b001, 32'h6,        32'h0,        32'h87654321, 32'h0,        1, 30'h1,       4'hC,  32'h0,        30'h0,  4'h0,  32'h0,        3, 0, 32'hFFFF8765, 0, 32'h0};
    vecs[8]  = '{1, 0, 3'b010, 32'h21,       32'h0,        32'h44332211, 32'h88776655, 2, 30'h8,       4'hE,  32'h0,        30'h9,  4'h1,  32'h0,        5, 0, 32'h55443322, 1, 32'h0};
    vecs[9]  = '{1, 0, 3'b101, 32'h0,        32'h0,        32'h0,        32'h0,        0, 30'h0,       4'h0,  32'h0,        30'h0,  4'h0,  32'h0,        2, 1, 32'h0,        0, 32'h0};
    vecs[10] = '{0, 1, 3'b000, 32'h0,        32'h12345678, 32'h0,        32'h0,        0, 30'h0,       4'h0,  32'h0,        30'h0,  4'h0,  32'h0,        2, 1, 32'h0,        0, 32'h0};
    vecs[11] = '{0, 1, 3'b110, 32'hFFFFFFFF, 32'h0000BEEF, 32'h0,        32'h0,        2, 30'h3FFFFFFF, 4'h8, 32'hEF000000, 30'h0,  4'h1,  32'h000000BE, 3, 0, 32'h0,        1, 32'hEF000000};
    vecs[12] = '{1, 0, 3'b011, 32'h3,        32'h0,        32'h80000000, 32'h0,        1, 30'h0,       4'h8,  32'h0,        30'h0,  4'h0,  32'h0,        3, 0, 32'h00000080, 0, 32'h0};
    vecs[13] = '{1, 0, 3'b000, 32'h3,        32'h0,        32'h80000000, 32'h0,        1, 30'h0,       4'h8,  32'h0,        30'h0,  4'h0,  32'h0,        3, 0, 32'hFFFFFF80, 0, 32'h0};
    vecs[14] = '{1, 1, 3'b111, 32'h4,        32'hCAFEF00D, 32'h0,        32'h0,        1, 30'h1,       4'hF,  32'hCAFEF00D, 30'h0,  4'h0,  32'h0,        2, 0, 32'h0,        0, 32'hCAFEF00D};
    vecs[15] = '{1, 0, 3'b001, 32'h5,        32'h0,        32'h00ABCD00, 32'h0,        1, 30'h1,       4'h6,  32'h0,        30'h0,  4'h0,  32'h0,        3, 0, 32'hFFFFABCD, 1, 32'h0};

    for (int i = 0; i < 16; i++) begin
      if (Trap && vecs[i].mis) begin
        vecs[i].beats = 0;
        vecs[i].e     = 1'b1;
        vecs[i].lat   = 2;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    cur_tag = 100;
    chk("rst_r_data", R_Data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_be", 32'(bus.mem_be), 0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      cur_tag = i;
      run_vec(vecs[i]);
    end

    // Timeout: grant never arrives, request must be held for 255 cycles.
    cur_tag = 200;
    gnt_en = 1'b0;
    hv = '{1, 0, 3'b010, 32'h20, 32'h0, 32'h11111111, 32'h0, 0, 30'h8, 4'hF, 32'h0, 30'h0, 4'h0, 32'h0, 256, 1, 32'h0, 0, 32'h0};
    run_vec(hv);
    chk("timeout_req_cycles", last_req_hi, 255);
    gnt_en = 1'b1;

    // Reset while the first read beat is waiting for rvalid.
    cur_tag = 300;
    mem_words[0] = 32'h5A5A5A5A;
    @(negedge clk);
    MemRead = 1'b1;
    Mode    = 3'b010;
    Address = 32'h0;
    W_Data  = 32'h0;
    @(posedge clk);
    #1;
    MemRead = 1'b0;
    @(posedge clk);
    #1;
    chk("wait0_req_low", bus.mem_req, 0);
    chk("wait0_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_req", bus.mem_req, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_r_data", R_Data, 0);
    reset = 1'b0;
    exp_r = 32'h0;

    cur_tag = 301;
    hv = '{0, 1, 3'b111, 32'h0, 32'h00000001, 32'hFFFFFFFF, 32'h0, 1, 30'h0, 4'hF, 32'h00000001, 30'h0, 4'h0, 32'h0, 2, 0, 32'h0, 0, 32'h00000001};
    run_vec(hv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
